// File: rtl/param_serializer.sv
// rtl/param_serializer.sv - double-buffered parallel-to-serial converter for the UART Tx path
// One-word holding register feeds a shifter; the next word is transferred on the last-bit ser_en.
module param_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    output logic                  load_ready,
    input  logic                  msb_first,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  ser_en,
    output logic                  ser_data,
    output logic                  ser_done,
    output logic                  par_bit,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                state_q, state_nx;
    logic                  hold_vld, hold_vld_nx;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_msb, hold_pe, hold_pt;
    logic [DATA_WIDTH-1:0] hold_rev;
    logic [DATA_WIDTH-1:0] shift_q, shift_nx;
    logic [CNT_W-1:0]      cnt_q, cnt_nx;
    logic                  par_q, par_nx;
    logic                  accept, last_bit, transfer;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            hold_vld <= 1'b0;
            shift_q  <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
        end else begin
            state_q  <= state_nx;
            hold_vld <= hold_vld_nx;
            shift_q  <= shift_nx;
            cnt_q    <= cnt_nx;
            par_q    <= par_nx;
        end
    end

    // Word attributes are captured with the data so each word carries its own framing.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hold_data <= '0;
            hold_msb  <= 1'b0;
            hold_pe   <= 1'b0;
            hold_pt   <= 1'b0;
        end else if (accept) begin
            hold_data <= P_DATA;
            hold_msb  <= msb_first;
            hold_pe   <= par_en;
            hold_pt   <= par_typ;
        end
    end

    always_comb begin
        hold_rev = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            hold_rev[i] = hold_data[DATA_WIDTH-1-i];
        end
    end

    always_comb begin
        accept   = Data_Valid && !hold_vld;
        last_bit = (state_q == S_SHIFT) && (cnt_q == LAST_IDX);
        transfer = hold_vld && ((state_q == S_IDLE) || (ser_en && last_bit));

        state_nx    = state_q;
        hold_vld_nx = hold_vld;
        shift_nx    = shift_q;
        cnt_nx      = cnt_q;
        par_nx      = par_q;

        // accept requires an empty hold and transfer a full one, so they never coincide
        if (accept) begin
            hold_vld_nx = 1'b1;
        end else if (transfer) begin
            hold_vld_nx = 1'b0;
        end

        if (transfer) begin
            state_nx = S_SHIFT;
            cnt_nx   = '0;
            shift_nx = hold_msb ? hold_rev : hold_data;
            par_nx   = hold_pe ? ((^hold_data) ^ hold_pt) : 1'b0;
        end else if ((state_q == S_SHIFT) && ser_en) begin
            shift_nx = {1'b0, shift_q[DATA_WIDTH-1:1]};
            if (last_bit) begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end else begin
                cnt_nx = cnt_q + CNT_W'(1);
            end
        end
    end

    assign load_ready = !hold_vld;
    assign busy       = (state_q == S_SHIFT);
    assign ser_data   = (state_q == S_SHIFT) ? shift_q[0] : 1'b1;
    assign ser_done   = last_bit;
    assign par_bit    = par_q;

endmodule

// File: tb/tb_param_serializer.sv
// tb/tb_param_serializer.sv - scoreboard bench for param_serializer at widths 8 and 5
module tb_param_serializer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic RST;

    logic [7:0] p_data;
    logic data_valid, msb_first, par_en, par_typ, ser_en;
    logic load_ready, ser_data, ser_done, par_bit, busy;

    logic [4:0] p_data5;
    logic data_valid5, msb_first5, par_en5, par_typ5, ser_en5;
    logic load_ready5, ser_data5, ser_done5, par_bit5, busy5;

    param_serializer #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(p_data), .Data_Valid(data_valid),
        .load_ready(load_ready), .msb_first(msb_first), .par_en(par_en),
        .par_typ(par_typ), .ser_en(ser_en), .ser_data(ser_data),
        .ser_done(ser_done), .par_bit(par_bit), .busy(busy)
    );

    param_serializer #(.DATA_WIDTH(5)) dut5 (
        .CLK(CLK), .RST(RST), .P_DATA(p_data5), .Data_Valid(data_valid5),
        .load_ready(load_ready5), .msb_first(msb_first5), .par_en(par_en5),
        .par_typ(par_typ5), .ser_en(ser_en5), .ser_data(ser_data5),
        .ser_done(ser_done5), .par_bit(par_bit5), .busy(busy5)
    );

    typedef struct packed {
        logic b;
        logic last;
        logic par;
    } exp_t;

    exp_t sb[$];
    exp_t sb5[$];
    int checks = 0;
    int errors = 0;

    function automatic void push_word(input logic [15:0] d, input int w,
                                      input logic m, input logic pe, input logic pt);
        exp_t e;
        logic p;
        p = 1'b0;
        for (int i = 0; i < w; i++) p ^= d[i];
        for (int i = 0; i < w; i++) begin
            e.b    = m ? d[w-1-i] : d[i];
            e.last = (i == w - 1);
            e.par  = pe ? (p ^ pt) : 1'b0;
            if (w == 8) sb.push_back(e);
            else sb5.push_back(e);
        end
    endfunction

    task automatic send_word(input logic [7:0] d, input logic m, input logic pe, input logic pt);
        int n;
        n = 0;
        @(negedge CLK);
        p_data = d; msb_first = m; par_en = pe; par_typ = pt; data_valid = 1'b1;
        while (!load_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout word=%h load_ready=%b required 1", d, load_ready);
        end else begin
            push_word({8'h00, d}, 8, m, pe, pt);
        end
        @(negedge CLK);
        data_valid = 1'b0;
    endtask

    task automatic consume(input int nbits, input int gap_idx, input int gap_len);
        int got, cyc, stall;
        logic started;
        exp_t e;
        got = 0; cyc = 0; stall = gap_len; started = 1'b0;
        while (got < nbits && cyc < 500) begin
            @(negedge CLK);
            cyc++;
            if (busy) begin
                started = 1'b1;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty bit=%0d ser_data=%b required none", got, ser_data);
                    ser_en = 1'b1;
                    got++;
                end else begin
                    e = sb[0];
                    checks++;
                    if (ser_data !== e.b) begin
                        errors++;
                        $display("FAIL ser_data bit=%0d got %b required %b", got, ser_data, e.b);
                    end
                    checks++;
                    if (ser_done !== e.last) begin
                        errors++;
                        $display("FAIL ser_done bit=%0d got %b required %b", got, ser_done, e.last);
                    end
                    checks++;
                    if (par_bit !== e.par) begin
                        errors++;
                        $display("FAIL par_bit bit=%0d got %b required %b", got, par_bit, e.par);
                    end
                    if (got == gap_idx && stall > 0) begin
                        ser_en = 1'b0;
                        stall--;
                    end else begin
                        ser_en = 1'b1;
                        void'(sb.pop_front());
                        got++;
                    end
                end
            end else begin
                if (started) begin
                    checks++; errors++;
                    $display("FAIL busy_drop bit=%0d busy=%b required 1", got, busy);
                end
                ser_en = 1'b1;
            end
        end
        checks++;
        if (got != nbits) begin
            errors++;
            $display("FAIL consume_timeout got %0d bits required %0d", got, nbits);
        end
        @(negedge CLK);
        ser_en = 1'b0;
    endtask

    task automatic check_idle(input logic exp_par);
        checks++;
        if (busy !== 1'b0 || ser_data !== 1'b1 || ser_done !== 1'b0) begin
            errors++;
            $display("FAIL idle busy/ser_data/ser_done got %b%b%b required 010", busy, ser_data, ser_done);
        end
        checks++;
        if (par_bit !== exp_par) begin
            errors++;
            $display("FAIL par_hold got %b required %b", par_bit, exp_par);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        data_valid = 0; p_data = '0; msb_first = 0; par_en = 0; par_typ = 0; ser_en = 0;
        data_valid5 = 0; p_data5 = '0; msb_first5 = 0; par_en5 = 0; par_typ5 = 0; ser_en5 = 0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({load_ready, busy, ser_done, ser_data, par_bit} !== 5'b10010) begin
            errors++;
            $display("FAIL reset8 lr/busy/done/data/par got %b required 10010",
                     {load_ready, busy, ser_done, ser_data, par_bit});
        end
        checks++;
        if ({load_ready5, busy5, ser_done5, ser_data5, par_bit5} !== 5'b10010) begin
            errors++;
            $display("FAIL reset5 lr/busy/done/data/par got %b required 10010",
                     {load_ready5, busy5, ser_done5, ser_data5, par_bit5});
        end
        RST = 1'b1;
    endtask

    task automatic test_lsb();
        send_word(8'hB1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (busy !== 1'b0 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL latency busy/load_ready got %b%b required 00", busy, load_ready);
        end
        consume(8, -1, 0);
        check_idle(1'b0);
    endtask

    task automatic test_msb_parity();
        send_word(8'hB1, 1'b1, 1'b1, 1'b1);
        consume(8, -1, 0);
        check_idle(1'b1);
        send_word(8'hB1, 1'b1, 1'b0, 1'b1);
        consume(8, -1, 0);
        check_idle(1'b0);
    endtask

    task automatic test_back_to_back();
        fork
            begin
                send_word(8'h0F, 1'b0, 1'b0, 1'b0);
                send_word(8'hF0, 1'b0, 1'b0, 1'b0);
                checks++;
                if (load_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_full load_ready got %b required 0", load_ready);
                end
            end
            consume(16, -1, 0);
        join
        check_idle(1'b0);
    endtask

    task automatic test_gap();
        send_word(8'hB1, 1'b0, 1'b1, 1'b0);
        consume(8, 2, 3);
        check_idle(1'b0);
    endtask

    task automatic test_reset_mid();
        send_word(8'hB1, 1'b0, 1'b1, 1'b1);
        send_word(8'h55, 1'b0, 1'b0, 1'b0);
        consume(3, -1, 0);
        RST = 1'b0;
        #1;
        checks++;
        if ({ser_data, busy, load_ready, par_bit, ser_done} !== 5'b10100) begin
            errors++;
            $display("FAIL reset_mid data/busy/lr/par/done got %b required 10100",
                     {ser_data, busy, load_ready, par_bit, ser_done});
        end
        sb.delete();
        @(negedge CLK);
        RST = 1'b1;
        send_word(8'h55, 1'b0, 1'b1, 1'b0);
        consume(8, -1, 0);
        check_idle(1'b0);
    endtask

    task automatic test_width5();
        int n, got;
        exp_t e;
        n = 0; got = 0;
        @(negedge CLK);
        p_data5 = 5'h13; msb_first5 = 0; par_en5 = 1; par_typ5 = 0; data_valid5 = 1;
        while (!load_ready5 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        push_word(16'h0013, 5, 1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        data_valid5 = 0;
        ser_en5 = 1;
        n = 0;
        while (got < 5 && n < 100) begin
            @(negedge CLK);
            n++;
            if (busy5 && sb5.size() > 0) begin
                e = sb5.pop_front();
                checks++;
                if ({ser_data5, ser_done5, par_bit5} !== {e.b, e.last, e.par}) begin
                    errors++;
                    $display("FAIL w5_bit%0d data/done/par got %b required %b", got,
                             {ser_data5, ser_done5, par_bit5}, {e.b, e.last, e.par});
                end
                got++;
            end
        end
        @(negedge CLK);
        ser_en5 = 0;
        checks++;
        if (got != 5 || busy5 !== 1'b0 || ser_data5 !== 1'b1 || par_bit5 !== 1'b1) begin
            errors++;
            $display("FAIL w5_end bits=%0d busy/data/par got %b%b%b required 5 011",
                     got, busy5, ser_data5, par_bit5);
        end
    endtask

    initial begin
        test_reset();
        test_lsb();
        test_msb_parity();
        test_back_to_back();
        test_gap();
        test_reset_mid();
        test_width5();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
